// File: rtl/sram_controller.sv
// Word-wide front end for the 16-bit asynchronous SRAM: each 32-bit read or
// write becomes a low-half phase followed by a high-half phase, with ready held low until done.
//
// state | meaning
// IDLE  | waiting for wr_en/rd_en; request fields latched on exit
// LOW   | accessing half-word {word,0} for PHASE_CYCLES cycles
// HIGH  | accessing half-word {word,1} for PHASE_CYCLES cycles
// DONE  | single completion cycle, ready high
module sram_controller #(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  tri   [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [17:0]   addr_q, addr_d;

  logic [31:0]   addr_diff;
  logic          last_cnt;
  logic          drive_wr;
  logic          unused_addr_bits;

  // Plain 32-bit subtract; addresses below BASE_ADDR simply wrap in the 17-bit word.
  assign addr_diff        = address - BASE_ADDR;
  assign unused_addr_bits = ^{addr_diff[31:19], addr_diff[1:0]};
  assign last_cnt         = (cnt_q == CNT_LAST);
  assign drive_wr         = wr_q && ((state_q == LOW) || (state_q == HIGH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          wr_d    = wr_en;
          word_d  = addr_diff[18:2];
          wdata_d = write_data;
          addr_d  = {addr_diff[18:2], 1'b0};
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (last_cnt) begin
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
          addr_d  = {word_q, 1'b1};
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (last_cnt) begin
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  // WE_N and the bus driver decode straight from state so a reset releases them without a clock.
  assign SRAM_WE_N = ~drive_wr;
  assign SRAM_DQ   = drive_wr ? ((state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
  assign SRAM_ADDR = addr_q;
  assign read_data = rdata_q;
  assign ready     = ((state_q == IDLE) && !wr_en && !rd_en) || (state_q == DONE);

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: a word-level reference memory predicts
// every access, and a negedge monitor checks pins, stall length and results.
`timescale 1ns/1ps
module tb_sram_controller;

  localparam int P     = 2;
  localparam int HALFS = 262144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  tri   [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, ce_n, oe_n, we_n;

  logic        wr_en1, rd_en1;
  logic [31:0] address1, write_data1, read_data1;
  logic        ready1;
  tri   [15:0] sram_dq1;
  logic [17:0] sram_addr1;
  logic        ub_n1, lb_n1, ce_n1, oe_n1, we_n1;

  sram_controller #(.PHASE_CYCLES(P), .BASE_ADDR(32'd1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n)
  );

  sram_controller #(.PHASE_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1), .SRAM_DQ(sram_dq1),
    .SRAM_ADDR(sram_addr1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1), .SRAM_CE_N(ce_n1),
    .SRAM_OE_N(oe_n1), .SRAM_WE_N(we_n1)
  );

  // SRAM device model: drives stored data during bench-issued reads, a zero
  // probe otherwise, so any controller drive while WE_N=1 corrupts the bus.
  logic [15:0] sram_mem [HALFS];
  bit          mem_init = 1'b0;
  logic        model_oe;
  assign sram_dq = (we_n && !ce_n && !oe_n) ? (model_oe ? sram_mem[sram_addr] : 16'h0000) : 16'bz;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < HALFS; i++) sram_mem[i] = 16'h0000;
      mem_init = 1'b1;
    end
    if (!we_n && !ce_n) sram_mem[sram_addr] = sram_dq;
  end

  logic [15:0] mem1 [4];
  always @(posedge clk) begin
    if (!we_n1 && (sram_addr1 < 18'd4)) mem1[sram_addr1[1:0]] = sram_dq1;
  end

  typedef struct {
    bit          is_wr;
    logic [16:0] word;
    logic [31:0] data;
    logic [31:0] exp_rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_e;
  logic [31:0] ref_mem [int];
  logic [31:0] last_read;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return w[16:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else if (wr_en || rd_en) begin
      if (!ready) begin
        if (exp_q.size() > 0) begin
          chk("stall_within_bound", 32'(cyc <= 2 * P), 32'd1);
          chk("we_n_phase", 32'(we_n), (exp_q[0].is_wr && cyc >= 1) ? 32'd0 : 32'd1);
          if (cyc >= 1 && cyc <= P)
            chk("addr_low", 32'(sram_addr), 32'({exp_q[0].word, 1'b0}));
          else if (cyc > P)
            chk("addr_high", 32'(sram_addr), 32'({exp_q[0].word, 1'b1}));
          if (exp_q[0].is_wr && cyc >= 1)
            chk("dq_write", 32'(sram_dq), (cyc <= P) ? 32'(exp_q[0].data[15:0]) : 32'(exp_q[0].data[31:16]));
          else if (!exp_q[0].is_wr)
            chk("dq_read_released", 32'(sram_dq), 32'(sram_mem[sram_addr]));
          else
            chk("dq_released", 32'(sram_dq), 32'd0);
        end
        cyc++;
      end else begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("stall_cycles", 32'(cyc), 32'(2 * P + 1));
          chk("read_data", read_data, mon_e.exp_rdata);
          chk("we_n_done", 32'(we_n), 32'd1);
          if (mon_e.is_wr) begin
            chk("sram_low_half", 32'(sram_mem[{mon_e.word, 1'b0}]), 32'(mon_e.data[15:0]));
            chk("sram_high_half", 32'(sram_mem[{mon_e.word, 1'b1}]), 32'(mon_e.data[31:16]));
            chk("dq_done", 32'(sram_dq), 32'd0);
          end
        end
        cyc = 0;
      end
    end else begin
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_we_n", 32'(we_n), 32'd1);
      chk("idle_dq", 32'(sram_dq), 32'd0);
    end
  end

  task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] data, input bit perturb);
    txn_t e;
    int   n;
    e.is_wr = wr;
    e.word  = word_of(addr);
    e.data  = data;
    if (wr) ref_mem[int'(e.word)] = data;
    else last_read = ref_mem.exists(int'(e.word)) ? ref_mem[int'(e.word)] : 32'h0;
    e.exp_rdata = last_read;
    exp_q.push_back(e);
    wr_en = wr; rd_en = rd; address = addr; write_data = data; model_oe = !wr;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready) break;
      if (perturb && n == 1) begin
        #2;
        address    = 32'd2000;
        write_data = $urandom;
      end
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: no ready after %0d cycles, required within %0d", n, 2 * P + 1);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; model_oe = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n1, lows, k;
    logic [31:0] a;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0; model_oe = 1'b0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = '0; write_data1 = '0;
    last_read = '0;
    #3;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_we_n", 32'(we_n), 32'd1);
    chk("reset_dq", 32'(sram_dq), 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_sram_addr", 32'(sram_addr), 32'd0);
    #20 rst_n = 1'b1;

    // PHASE_CYCLES=1 instance: write at 1024, ready expected in cycle 3
    @(posedge clk); #1;
    wr_en1 = 1'b1; address1 = 32'd1024; write_data1 = 32'h12345678;
    n1 = 0; lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready1) begin n1 = c; break; end
      if (!we_n1) lows++;
    end
    chk("p1_ready_cycle", 32'(n1), 32'd3);
    chk("p1_we_low_cycles", 32'(lows), 32'd2);
    @(posedge clk); #1 wr_en1 = 1'b0;
    @(negedge clk);
    chk("p1_sram_lo", 32'(mem1[0]), 32'h5678);
    chk("p1_sram_hi", 32'(mem1[1]), 32'h1234);
    chk("p1_read_data", read_data1, 32'd0);
    chk("p1_tieoffs", 32'({ub_n1, lb_n1, ce_n1, oe_n1}), 32'd0);
    chk("tieoffs", 32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);

    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'd1024, 32'h12345678, 1'b0);
    do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    do_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    do_access(1'b1, 1'b0, 32'd1036, 32'h0BADC0DE, 1'b1);
    do_access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
    do_access(1'b0, 1'b1, 32'd2000, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted in the middle of the HIGH phase of a write
    wr_en = 1'b1; address = 32'd1424; write_data = 32'hA5A55A5A;
    repeat (3) @(posedge clk);
    #2;
    chk("we_n_before_reset", 32'(we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_we_n", 32'(we_n), 32'd1);
    chk("abort_dq", 32'(sram_dq), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_sram_addr", 32'(sram_addr), 32'd0);
    wr_en = 1'b0;
    last_read = 32'd0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) a = 32'd1024 - 32'(4 * $urandom_range(1, 4));
      else a = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      a = a + 32'($urandom_range(0, 3));
      case (k)
        0:       do_access(1'b1, 1'b0, a, $urandom, 1'b0);
        1:       do_access(1'b0, 1'b1, a, 32'h0, 1'b0);
        2:       do_access(1'b1, 1'b1, a, $urandom, 1'b0);
        default: do_access(1'b1, 1'b0, a, $urandom, 1'b1);
      endcase
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Initiator-side controller for the board's 16-bit asynchronous SRAM, sitting between the processor's MEM stage and the external `SRAM_*` pins. It converts one 32-bit word read or write into two sequential 16-bit SRAM accesses: low half first, then high half. While an access is in progress it holds `ready` low so the pipeline freezes. It drives exactly the pin set of the on-board SRAM and of the simulation SRAM model, so it is usable both on FPGA and in ModelSim.

## Interface
- `PHASE_CYCLES`, 2: clock cycles per half-word phase. Legal range is ≥1.
- `BASE_ADDR`, 1024: processor byte address that maps to SRAM word 0.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: word write request from MEM stage. Held until `ready`.
- `rd_en` input 1: word read request from MEM stage. Held until `ready`.
- `address` input 32: processor byte address.
- `write_data` input 32: word to write.
- `read_data` output 32: last word read.
- `ready` output 1: high means the MEM stage may advance.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output 18: SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N` output 1 each: byte lane enables, tied to 0.
- `SRAM_CE_N`, `SRAM_OE_N` output 1 each: chip enable and output enable, tied to 0.
- `SRAM_WE_N` output 1: write enable, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE. A phase counter `cnt` counts 0..PHASE_CYCLES-1.
- IDLE: if `wr_en|rd_en`, latch the following, clear `cnt`, and go to LOW. Otherwise stay.
  - operation: write if `wr_en`, else read. Write wins when both are high.
  - `word = (address - BASE_ADDR) >> 2`.
  - `write_data`.
- LOW:
  - `SRAM_ADDR = {word[16:0],1'b0}`.
  - `cnt` increments each cycle. At `cnt==PHASE_CYCLES-1`, go to HIGH and clear `cnt`.
- HIGH:
  - `SRAM_ADDR = {word[16:0],1'b1}`.
  - Same counting as LOW. On exit go to DONE.
- DONE: single cycle, then always IDLE.
- Write phases:
  - `SRAM_WE_N=0` for the whole phase.
  - `SRAM_DQ` driven with latched data: `[15:0]` in LOW, `[31:16]` in HIGH.
- Read phases and all other states:
  - `SRAM_WE_N=1`, `SRAM_DQ=16'bz`.
  - On the last cycle of LOW, capture `SRAM_DQ` into `read_data[15:0]`.
  - On the last cycle of HIGH, capture `SRAM_DQ` into `read_data[31:16]`.
- `read_data` is unchanged by writes. It holds its value until the next read overwrites it.
- `ready` is combinational: `(state==IDLE & ~wr_en & ~rd_en) | (state==DONE)`.
- Address arithmetic:
  - 32-bit subtraction, then truncation to 17 word bits.
  - No range check. Addresses below BASE_ADDR wrap modulo 2^17 words.
  - `address[1:0]` is ignored.
- SRAM_ADDR outside active phases: holds its last value. Value is don't-care; reset value is 0.

## Timing
- Reset values (asserted asynchronously while `rst_n=0`):
  - state IDLE, `cnt=0`.
  - `read_data=0`, `SRAM_ADDR=0`.
  - `SRAM_WE_N=1`, `SRAM_DQ=z`.
  - `ready` then follows the IDLE rule.
- Reset mid-operation: abort immediately. `WE_N` returns to 1 with no clock edge; a partial write may leave the low half updated. No completion signal is issued.
- Request latency: request sampled in IDLE at edge E0.
  - LOW occupies cycles 1..P, HIGH occupies P+1..2P, DONE is cycle 2P+1.
  - With P=2, `ready` is low for cycle 0 through cycle 4 and high in cycle 5.
  - Total stall: 2P+1 cycles. Access occupancy: 2P+2 cycles including the request cycle.
- At the edge ending DONE the pipeline advances. The next request is seen in IDLE one cycle later, so there are no back-to-back accesses without an IDLE cycle.
- Request inputs are ignored outside IDLE. `address`/`write_data` changes mid-access have no effect.
- `rd_en`/`wr_en` deasserting mid-access does not cancel it.

## Test plan
- Reset check: assert `rst_n=0` mid-HIGH of a write.
  - Required: `SRAM_WE_N=1`, `SRAM_DQ=z`, `read_data=0` without a clock edge.
  - After release, IDLE with `ready=1`.
- Write, P=2: `wr_en=1`, `address=1024`, `write_data=0x12345678`.
  - Required: SRAM addr 0 = 0x5678, SRAM addr 1 = 0x1234.
  - `WE_N` low for exactly cycles 1-4; `ready` first high in cycle 5.
- Read-back: after writing 0xDEADBEEF at 1028, read 1028.
  - Required: SRAM addrs 2/3 accessed and `read_data=0xDEADBEEF` in DONE.
  - `SRAM_DQ` never driven by the controller during the read.
- Simultaneous request: `wr_en=rd_en=1`, address 1032, data 0xCAFEF00D.
  - Required: a write is performed to SRAM addrs 4/5; `read_data` unchanged.
- Input change mid-access: change `address` to 2000 and `write_data` during LOW.
  - Required: the HIGH half is still written to the originally latched word.
- Idle behaviour:
  - With no requests, `ready=1`, `SRAM_WE_N=1`, `SRAM_DQ=z`.
  - Under PHASE_CYCLES=1 the write at 1024 completes with `ready` high in cycle 3.
